// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner emitting debounced hex key codes with a one-cycle strobe.
// Define KEYPAD_REPEAT_EN to add auto-repeat strobes every REPEAT_DIV samples while a key is held.
module keypad_scan #(
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_CNT    = 4,
    parameter int REPEAT_DIV = 200
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEB_CNT + 1);
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;
    state_t state, state_n;
    logic [CW-1:0] dwell;
    logic [DW-1:0] match_cnt, match_n, rel_cnt, rel_n;
    logic [3:0] r1, rs, pat, pat_n, key_n;
    logic [1:0] col_idx, col_idx_n, row_idx;
    logic sample, idle, single, key_valid_n, key_held_n;
`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DIV + 1);
    logic [RW-1:0] rep_cnt, rep_n;
`endif
    assign sample  = dwell == CW'(SCAN_DIV - 1);
    assign idle    = rs == 4'hF;
    assign single  = $onehot(~rs);
    assign row_idx = !pat[0] ? 2'd0 : !pat[1] ? 2'd1 : !pat[2] ? 2'd2 : 2'd3;
    assign col     = ~(4'b0001 << col_idx);
    always_comb begin
        state_n     = state;
        col_idx_n   = col_idx;
        pat_n       = pat;
        match_n     = match_cnt;
        rel_n       = rel_cnt;
        key_n       = key;
        key_valid_n = 1'b0;
        key_held_n  = key_held;
`ifdef KEYPAD_REPEAT_EN
        rep_n       = rep_cnt;
`endif
        if (sample) begin
            case (state)
                SCAN: begin
                    // multi-key patterns are ghosts: keep scanning as if idle
                    if (single) begin
                        pat_n   = rs;
                        match_n = DW'(1);
                        state_n = DEBOUNCE;
                    end else begin
                        col_idx_n = col_idx + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (rs != pat) begin
                        state_n   = SCAN;
                        col_idx_n = col_idx + 1'b1;
                    end else if (match_cnt == DW'(DEB_CNT - 1)) begin
                        key_n       = {row_idx, col_idx};
                        key_valid_n = 1'b1;
                        key_held_n  = 1'b1;
                        rel_n       = '0;
                        state_n     = HOLD;
`ifdef KEYPAD_REPEAT_EN
                        rep_n       = '0;
`endif
                    end else begin
                        match_n = match_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!idle) begin
                        rel_n = '0;
`ifdef KEYPAD_REPEAT_EN
                        key_valid_n = rep_cnt == RW'(REPEAT_DIV - 1);
                        rep_n       = key_valid_n ? '0 : rep_cnt + 1'b1;
`endif
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        rep_n = '0;
`endif
                        if (rel_cnt == DW'(DEB_CNT - 1)) begin
                            key_held_n = 1'b0;
                            rel_n      = '0;
                            col_idx_n  = col_idx + 1'b1;
                            state_n    = SCAN;
                        end else begin
                            rel_n = rel_cnt + 1'b1;
                        end
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= SCAN;
            dwell     <= '0;
            r1        <= 4'hF;
            rs        <= 4'hF;
            pat       <= 4'hF;
            col_idx   <= '0;
            match_cnt <= '0;
            rel_cnt   <= '0;
            key       <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            state     <= state_n;
            dwell     <= sample ? '0 : dwell + 1'b1;
            r1        <= row;
            rs        <= r1;
            pat       <= pat_n;
            col_idx   <= col_idx_n;
            match_cnt <= match_n;
            rel_cnt   <= rel_n;
            key       <= key_n;
            key_valid <= key_valid_n;
            key_held  <= key_held_n;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= rep_n;
`endif
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: physical keypad emulation with random presses, checked per dwell against a
// sample-level reference model built from run-length counters.
`timescale 1ns/1ps
module tb_keypad_scan;
    localparam int SD = 4, DEB = 3, REP = 5;
    logic clk = 1'b0, clr = 1'b1;
    logic [3:0] row, col, key;
    logic key_valid, key_held;
    logic [15:0] keys = '0;
    int n_chk = 0, n_pass = 0, n_strobe = 0, s0 = 0;
    int m_col = 0, m_run = 0, m_idle = 0, m_rep = 0;
    bit m_held = 0, m_valid = 0;
    logic [3:0] m_pat = 4'hF, m_key = '0, m_code = '0;
    logic [15:0] cur = '0;

    keypad_scan #(.SCAN_DIV(SD), .DEB_CNT(DEB), .REPEAT_DIV(REP)) dut (
        .clk(clk), .clr(clr), .row(row), .col(col),
        .key(key), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] colv(input int c);
        return ~(4'b0001 << c);
    endfunction

    // a pressed key pulls its row low whenever its column is driven low
    function automatic logic [3:0] rows_seen(input logic [15:0] k, input logic [3:0] cv);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 16; i++) if (k[i] && !cv[i % 4]) r[i / 4] = 1'b0;
        return r;
    endfunction

    always_comb row = rows_seen(keys, col);

    always @(posedge clk) if (key_valid === 1'b1) n_strobe++;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_sample();
        logic [3:0] rs;
        int lows, r_idx;
        rs = rows_seen(keys, colv(m_col));
        lows = 0;
        r_idx = 0;
        m_valid = 0;
        for (int r = 3; r >= 0; r--) if (!rs[r]) begin lows++; r_idx = r; end
        if (m_held) begin
            if (rs == 4'hF) begin
                m_rep = 0;
                m_idle++;
                if (m_idle == DEB) begin m_held = 0; m_idle = 0; m_col = (m_col + 1) % 4; end
            end else begin
                m_idle = 0;
`ifdef KEYPAD_REPEAT_EN
                m_rep++;
                if (m_rep == REP) begin m_rep = 0; m_valid = 1; end
`endif
            end
        end else if (m_run > 0) begin
            if (rs != m_pat) begin
                m_run = 0;
                m_col = (m_col + 1) % 4;
            end else begin
                m_run++;
                if (m_run == DEB) begin m_run = 0; m_held = 1; m_valid = 1; m_key = m_code; m_rep = 0; end
            end
        end else if (lows == 1) begin
            m_pat = rs;
            m_run = 1;
            m_code = 4'(4 * r_idx + m_col);
        end else begin
            m_col = (m_col + 1) % 4;
        end
    endtask

    task automatic dwell(input logic [15:0] k);
        keys = k;
        for (int i = 0; i < SD; i++) begin
            @(posedge clk);
            #1;
            if (i < SD - 1) begin
                check("kv_between", key_valid, 0);
                check("col_steady", col, colv(m_col));
            end else begin
                model_sample();
                check("col", col, colv(m_col));
                check("key", key, m_key);
                check("key_valid", key_valid, m_valid);
                check("key_held", key_held, m_held);
            end
        end
    endtask

    task automatic do_reset();
        clr = 1'b1;
        keys = '0;
        @(posedge clk);
        #1;
        check("rst_col", col, 4'b1110);
        check("rst_key", key, 0);
        check("rst_kv", key_valid, 0);
        check("rst_held", key_held, 0);
        @(negedge clk);
        clr = 1'b0;
        m_col = 0; m_run = 0; m_idle = 0; m_rep = 0; m_held = 0; m_valid = 0; m_key = '0;
    endtask

    task automatic press_until_detect(input logic [15:0] k);
        int n;
        n = 0;
        while (m_run == 0 && n < 8) begin dwell(k); n++; end
        check("detect", m_run, 1);
    endtask

    initial begin
        do_reset();
        // idle scan
        s0 = n_strobe;
        repeat (8) dwell('0);
        check("idle_strobes", n_strobe - s0, 0);
        // clean press of code 6 then release
        s0 = n_strobe;
        press_until_detect(16'h0040);
        repeat (6) dwell(16'h0040);
        check("p6_strobes", n_strobe - s0, 1);
        check("p6_key", key, 6);
        check("p6_col", col, 4'b1011);
        check("p6_held", key_held, 1);
        repeat (3) dwell('0);
        check("rel_held", key_held, 0);
        check("rel_col", col, 4'b0111);
        check("rel_strobes", n_strobe - s0, 1);
        // bounce during debounce
        s0 = n_strobe;
        press_until_detect(16'h0040);
        dwell('0);
        check("bounce_held", key_held, 0);
        check("bounce_strobes", n_strobe - s0, 0);
        press_until_detect(16'h0040);
        repeat (3) dwell(16'h0040);
        check("bounce_accept", n_strobe - s0, 1);
        repeat (4) dwell('0);
        // ghost: rows 0 and 2 in column 1
        s0 = n_strobe;
        repeat (8) dwell(16'h0202);
        check("ghost_strobes", n_strobe - s0, 0);
        check("ghost_held", key_held, 0);
        // clr while debouncing code 4
        press_until_detect(16'h0010);
        s0 = n_strobe;
        do_reset();
        repeat (4) dwell('0);
        check("clr_strobes", n_strobe - s0, 0);
        // random presses, multi-key patterns and bounces
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0)
                cur = ($urandom_range(0, 3) == 0) ? 16'h0 :
                      ($urandom_range(0, 2) == 0) ? (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15)) :
                      16'h1 << $urandom_range(0, 15);
            dwell(($urandom_range(0, 7) == 0) ? 16'h0 : cur);
        end
        repeat (6) dwell('0);
        // key F held for 20 samples
        s0 = n_strobe;
        press_until_detect(16'h8000);
        repeat (19) dwell(16'h8000);
        repeat (4) dwell('0);
        check("f_key", key, 15);
`ifdef KEYPAD_REPEAT_EN
        check("f_strobes", n_strobe - s0, 4);
`else
        check("f_strobes", n_strobe - s0, 1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
